// File: rtl/ks_prefix_tail_pipe.sv
// Kogge-Stone adder tail: prefix layers 4 and 5 plus the sum/flag stage,
// arranged as a three-stage valid/ready pipeline with a completed-transfer counter.
`timescale 1ns/1ps
module ks_prefix_tail_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      H,
  input  logic [15:0]      I,
  input  logic [15:0]      P,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      S,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count
);

  logic             v1, v2, v3;
  logic [15:0]      j1, k1, p1;
  logic             cin1;
  logic [15:0]      g2, pg2, p2;
  logic             cin2;
  logic [15:0]      s3;
  logic             cout3, ovf3;
  logic [CNT_W-1:0] cnt_q;

  logic             adv1, adv2, adv3;
  logic [15:0]      j_n, k_n, g_n, pg_n, s_n;
  logic [16:0]      c;

  // Each stage loads when empty or when the stage after it loads; this
  // collapses bubbles while the output is stalled.
  assign adv3     = !v3 || out_ready;
  assign adv2     = !v2 || adv3;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1 && !rst;

  always_comb begin
    j_n = H;
    k_n = I;
    for (int unsigned k = 4; k < 16; k++) begin
      j_n[k] = H[k] & H[k-4];
      k_n[k] = I[k] | (H[k] & I[k-4]);
    end
  end

  always_comb begin
    pg_n = j1;
    g_n  = k1;
    for (int unsigned k = 8; k < 16; k++) begin
      pg_n[k] = j1[k] & j1[k-8];
      g_n[k]  = k1[k] | (j1[k] & k1[k-8]);
    end
  end

  // After layer 5 every group reaches bit 0, so each carry needs only cin.
  always_comb begin
    c    = '0;
    c[0] = cin2;
    for (int unsigned k = 0; k < 16; k++) begin
      c[k+1] = g2[k] | (pg2[k] & cin2);
    end
    s_n = p2 ^ c[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      j1    <= '0;
      k1    <= '0;
      p1    <= '0;
      cin1  <= 1'b0;
      g2    <= '0;
      pg2   <= '0;
      p2    <= '0;
      cin2  <= 1'b0;
      s3    <= '0;
      cout3 <= 1'b0;
      ovf3  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (adv1) begin
        v1   <= in_valid;
        j1   <= j_n;
        k1   <= k_n;
        p1   <= P;
        cin1 <= cin;
      end
      if (adv2) begin
        v2   <= v1;
        g2   <= g_n;
        pg2  <= pg_n;
        p2   <= p1;
        cin2 <= cin1;
      end
      if (adv3) begin
        v3    <= v2;
        s3    <= s_n;
        cout3 <= c[16];
        ovf3  <= c[16] ^ c[15];
      end
      if (v3 && out_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = v3;
  assign S         = v3 ? s3 : '0;
  assign cout      = v3 ? cout3 : 1'b0;
  assign ovf       = v3 ? ovf3 : 1'b0;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_ks_prefix_tail_pipe.sv
// Bench for ks_prefix_tail_pipe: directed vector table, random burst, stall,
// mid-flight reset and counter wrap, all checked through an in-order scoreboard.
`timescale 1ns/1ps
module tb_ks_prefix_tail_pipe;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] h_s, i_s, p_s;
  logic        cin_s;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] s_o;
  logic        cout_o, ovf_o;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  op_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t cur_exp;
  res_t sb[$];
  logic [3:0] exp_cnt;
  vec_t tbl[7];

  ks_prefix_tail_pipe #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .H(h_s), .I(i_s), .P(p_s), .cin(cin_s),
    .in_valid(in_valid), .in_ready(in_ready),
    .S(s_o), .cout(cout_o), .ovf(ovf_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Layers 1-3 reference: half-sum/generate, then prefix distances 1 and 2.
  function automatic void ref_pre(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] h, output logic [15:0] i,
                                  output logic [15:0] p);
    logic [15:0] g0, p0, g1, p1;
    g0 = a & b;
    p0 = a ^ b;
    g1 = g0;
    p1 = p0;
    for (int k = 1; k < 16; k++) begin
      g1[k] = g0[k] | (p0[k] & g0[k-1]);
      p1[k] = p0[k] & p0[k-1];
    end
    h = p1;
    i = g1;
    for (int k = 2; k < 16; k++) begin
      i[k] = g1[k] | (p1[k] & g1[k-2]);
      h[k] = p1[k] & p1[k-2];
    end
    p = p0;
  endfunction

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] sum;
    res_t r;
    sum    = {1'b0, a} + {1'b0, b} + 17'(c);
    r.s    = sum[15:0];
    r.cout = sum[16];
    r.ovf  = (a[15] == b[15]) && (sum[15] != a[15]);
    return r;
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c, input res_t e);
    logic [15:0] h, i, p;
    ref_pre(a, b, h, i, p);
    h_s     = h;
    i_s     = i;
    p_s     = p;
    cin_s   = c;
    cur_exp = e;
  endtask

  task automatic wait_accept(input string name);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk(name, 32'(0), 32'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input res_t e);
    drive(a, b, c, e);
    in_valid = 1'b1;
    wait_accept("accept_timeout");
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [15:0] a, b;
    logic        c;
    a = 16'($urandom);
    b = 16'($urandom);
    c = 1'($urandom);
    send(a, b, c, model(a, b, c));
  endtask

  task automatic send_lat(input vec_t v);
    send(v.a, v.b, v.c, v.exp);
    @(negedge clk); chk("lat_cycle1_out_valid", 32'(out_valid), 32'(0));
    @(negedge clk); chk("lat_cycle2_out_valid", 32'(out_valid), 32'(0));
    @(negedge clk); chk("lat_cycle3_out_valid", 32'(out_valid), 32'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(posedge clk);
      #1;
      ok = (sb.size() == 0) && !out_valid;
    end
    chk("drain_complete", 32'(ok), 32'(1));
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: decides at the negedge which transfers the next posedge will make.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_cnt = '0;
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
    end else begin
      if (!out_valid) chk("idle_outputs_zero", 32'({s_o, cout_o, ovf_o}), 32'(0));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(1), 32'(0));
        end else begin
          res_t e;
          e = sb.pop_front();
          chk("result", 32'({s_o, cout_o, ovf_o}), 32'(e));
        end
        chk("op_count_track", 32'(op_count), 32'(exp_cnt));
        exp_cnt = exp_cnt + 4'd1;
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL global_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, '{16'h0100, 1'b0, 1'b0}};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    tbl[3] = '{16'h0000, 16'h0000, 1'b1, '{16'h0001, 1'b0, 1'b0}};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, '{16'hFFFF, 1'b1, 1'b0}};
    tbl[6] = '{16'h1234, 16'h4321, 1'b0, '{16'h5555, 1'b0, 1'b0}};

    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    drive(16'hAAAA, 16'h5555, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("reset_op_count", 32'(op_count), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'(1));
    chk("post_reset_out_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;

    foreach (tbl[n]) begin
      send_lat(tbl[n]);
      if (n == 0) chk("first_op_count", 32'(op_count), 32'(1));
    end
    drain();

    // Back-to-back random burst: one accept and, once filled, one result per cycle.
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      logic [15:0] a, b;
      logic        c;
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      drive(a, b, c, model(a, b, c));
      @(negedge clk);
      chk("burst_in_ready", 32'(in_ready), 32'(1));
      if (n >= 3) chk("burst_out_valid", 32'(out_valid), 32'(1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    // Stall: three ops fill the pipe, the fourth is held off until release.
    out_ready = 1'b0;
    repeat (3) send_rand();
    begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      drive(a, b, 1'b1, model(a, b, 1'b1));
    end
    in_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      chk("stall_out_valid", 32'(out_valid), 32'(1));
      chk("stall_sb_depth", 32'(sb.size()), 32'(3));
      if (sb.size() > 0) chk("stall_outputs_hold", 32'({s_o, cout_o, ovf_o}), 32'(sb[0]));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_accept("stall_release_accept");
    in_valid = 1'b0;
    drain();

    // Reset with two operations in flight: neither may emerge.
    send_rand();
    send_rand();
    pulse_rst();
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_op_count", 32'(op_count), 32'(0));
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("midrst_no_output", 32'(out_valid), 32'(0));
    end
    @(posedge clk);
    #1;
    send_lat(tbl[0]);
    chk("midrst_next_op_count", 32'(op_count), 32'(1));
    drain();

    // Counter wrap with a 4-bit counter.
    pulse_rst();
    repeat (15) send_rand();
    drain();
    chk("count_at_15", 32'(op_count), 32'(15));
    send_rand();
    drain();
    chk("count_wrapped", 32'(op_count), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ks_prefix_tail_pipe.md
KS_PREFIX_TAIL_PIPE -- requirements
Module: ks_prefix_tail_pipe

Interface
REQ-001 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 H  input  16  group propagate after prefix layer 3; H[k] spans bits k..k-3, or down to bit 0 when k<3.
REQ-005 I  input  16  group generate after prefix layer 3, same spans as H.
REQ-006 P  input  16  bitwise half-sum A^B from the pre-processing layer.
REQ-007 cin  input  1  carry-in for the operation.
REQ-008 in_valid  input  1  H/I/P/cin valid this cycle.
REQ-009 in_ready  output  1  block accepts input this cycle.
REQ-010 S  output  16  sum.
REQ-011 cout  output  1  carry out of bit 15.
REQ-012 ovf  output  1  two's-complement overflow.
REQ-013 out_valid  output  1  S/cout/ovf valid.
REQ-014 out_ready  input  1  downstream accepts output this cycle.
REQ-015 op_count  output  CNT_W  number of completed output transfers.

Function
REQ-016 Three register stages SHALL be used: ST1 = prefix layer 4 (distance 4), ST2 = prefix layer 5 (distance 8), ST3 = sum/flags.
REQ-017 Layer 4: for k>=4, J[k]=H[k]&H[k-4] and K[k]=I[k]|(H[k]&I[k-4]); for k<4, J[k]=H[k] and K[k]=I[k]; the result SHALL be registered in ST1.
REQ-018 Layer 5: the same rule with distance 8 applied to ST1 contents (pass-through for k<8); the result SHALL be registered in ST2 as G[15:0] and Pg[15:0].
REQ-019 Carries: c[0]=cin; c[k+1]=G[k]|(Pg[k]&cin) for k=0..15.
REQ-020 Sum and flags: S[k]=P[k]^c[k]; cout=c[16]; ovf=c[16]^c[15]; all registered in ST3.
REQ-021 P and cin SHALL travel with their operation through ST1 and ST2, so that every stage holds one coherent operation.
REQ-022 Each stage SHALL hold a valid bit v1, v2 and v3; out_valid = v3.
REQ-023 Transfer rules: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
REQ-024 Stage n SHALL advance (load from stage n-1) when stage n is empty or stage n is advancing downstream; otherwise it holds its contents and valid bit unchanged.
REQ-025 in_ready SHALL equal !v1 | ST1 advancing; it is combinational from out_ready through the stall chain.
REQ-026 Latency SHALL be 3 cycles from input transfer to out_valid when there is no stall; sustained throughput SHALL be 1 operation per cycle with out_ready held high.
REQ-027 Under stall, out_valid=1 with out_ready=0 SHALL hold S, cout and ovf stable; no operation is dropped or duplicated.
REQ-028 A bubble (v=0) between stages SHALL be collapsed when the downstream stage advances into it while the output is stalled.
REQ-029 op_count SHALL increment by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.
REQ-030 Data registers of stages with v=0 are don't-care; outputs S, cout and ovf SHALL read 0 whenever out_valid=0.

Reset
REQ-031 While rst=1 at a clock edge: v1=v2=v3=0, op_count=0, and all data registers cleared to 0.
REQ-032 During reset, in_ready SHALL be 0 and out_valid SHALL be 0; in_valid is ignored.
REQ-033 A reset asserted mid-operation SHALL discard all in-flight operations; the first cycle after rst deasserts, in_ready=1 and out_valid=0.

Verification
REQ-034 A=0x00FF, B=0x0001, cin=0 (H/I/P from reference layers 1-3 model), out_ready=1 -> 3 cycles later S=0x0100, cout=0, ovf=0, op_count=1.
REQ-035 A=0xFFFF, B=0x0001, cin=0 -> S=0x0000, cout=1, ovf=0; A=0x7FFF, B=0x0001 -> S=0x8000, cout=0, ovf=1; A=0x0000, B=0x0000, cin=1 -> S=0x0001.
REQ-036 Back-to-back 100 random operations with out_ready=1 -> one result per cycle, in order, each matching A+B+cin.
REQ-037 Fill the pipe, then hold out_ready=0 for 5 cycles -> in_ready=0 after 3 accepted operations, outputs stable; release -> all 3 results delivered in order with none lost.
REQ-038 Assert rst for 1 cycle with 2 operations in flight -> none emerge, op_count=0, and the next operation completes normally after 3 cycles.
REQ-039 Preload op_count to 2^CNT_W-1 (CNT_W=4, i.e. 15) via 15 transfers, then 1 more transfer -> op_count=0.
